// File: rtl/lab_restoring_divider_pkg.sv
// Shared constants and types for the 8-by-4 restoring divider.
// Widths are fixed by the 4-bit borrow-lookahead subtractor.
package lab_restoring_divider_pkg;

    localparam int DVD_W = 8;
    localparam int DVS_W = 4;
    localparam int CNT_W = $clog2(DVD_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [DVD_W-1:0] DIV0_QUOT = 8'hFF;

endpackage

// File: rtl/lab_restoring_divider_if.sv
// Start/done request bus of the divider; master issues operands, slave returns results.
interface lab_restoring_divider_if;
    import lab_restoring_divider_pkg::*;

    logic             start;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic             busy;
    logic             done;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/Lab2_4_bit_BLS.sv
// 4-bit borrow-lookahead subtractor: Diff = X - Y - Bin, Bout set on underflow.
module Lab2_4_bit_BLS (
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       Bin,
    output logic [3:0] Diff,
    output logic       Bout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] b;

    // g: stage generates a borrow on its own; p: stage passes an incoming borrow on
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_gp
            assign g[gi] = ~X[gi] & Y[gi];
            assign p[gi] = ~(X[gi] ^ Y[gi]);
            assign Diff[gi] = X[gi] ^ Y[gi] ^ b[gi];
        end
    endgenerate

    assign b[0] = Bin;
    assign b[1] = g[0] | (p[0] & b[0]);
    assign b[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & b[0]);
    assign b[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & b[0]);
    assign b[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & b[0]);
    assign Bout = b[4];

endmodule

// File: rtl/lab_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock through the
// 4-bit borrow-lookahead subtractor, start/done handshake on the request bus.
module lab_restoring_divider #(
    parameter int DVD_W = lab_restoring_divider_pkg::DVD_W,
    parameter int DVS_W = lab_restoring_divider_pkg::DVS_W
) (
    input  logic                          clk,
    input  logic                          rst,
    lab_restoring_divider_if.slave        bus
);
    import lab_restoring_divider_pkg::*;

    state_e           state_q, state_d;
    logic [DVS_W-1:0] r_q, r_d;
    logic [DVD_W-1:0] q_q, q_d;
    logic [DVS_W-1:0] d_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DVD_W-1:0] quot_q;
    logic [DVS_W-1:0] rem_q;
    logic             dz_q;

    logic [DVS_W-1:0] rs;
    logic [DVS_W-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             qbit;

    Lab2_4_bit_BLS u_bls (
        .X    (rs),
        .Y    (d_q),
        .Bin  (1'b0),
        .Diff (diff),
        .Bout (bout)
    );

    // A set R[3] means the shifted remainder is really >= 16, so the subtract always fits
    always_comb begin
        rs   = {r_q[DVS_W-2:0], q_q[DVD_W-1]};
        ovf  = r_q[DVS_W-1];
        qbit = ovf | ~bout;
        r_d  = qbit ? diff : rs;
        q_d  = {q_q[DVD_W-2:0], qbit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Divide-by-zero also passes through CALC, with a zero count, so done lands one cycle later
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE);
    end

    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dz_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        d_q   <= bus.divisor;
                        q_q   <= bus.dividend;
                        r_q   <= '0;
                        cnt_q <= (bus.divisor == '0) ? '0 : CNT_W'(DVD_W - 1);
                        dz_q  <= 1'b0;
                    end
                end
                CALC: begin
                    r_q <= r_d;
                    q_q <= q_d;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (d_q == '0) begin
                        quot_q <= DIV0_QUOT;
                        rem_q  <= '0;
                        dz_q   <= 1'b1;
                    end else begin
                        quot_q <= q_d;
                        rem_q  <= r_d;
                        dz_q   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab_restoring_divider.sv
// Self-checking bench for lab_restoring_divider: vector table, corner sequences, full operand sweep.
module tb_lab_restoring_divider;

    logic clk;
    logic rst;

    lab_restoring_divider_if bus ();

    lab_restoring_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dvd;
        logic [3:0] dvs;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } exp_t;

    vec_t vecs [7];
    exp_t sb_q [$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("quotient", int'(bus.quotient), int'(e.q));
                check("remainder", int'(bus.remainder), int'(e.r));
                check("div_by_zero", int'(bus.div_by_zero), int'(e.dz));
            end
        end
    end

    // Called #1 after a rising edge while idle; returns #1 after the edge where busy drops
    task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er, input logic edz,
                          input bit chk_lat);
        int lat;
        int busy_cnt;
        int done_lat;
        exp_t e;
        e.q = eq; e.r = er; e.dz = edz;
        sb_q.push_back(e);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        busy_cnt = bus.busy ? 1 : 0;
        lat      = 0;
        done_lat = -1;
        while (bus.busy && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) busy_cnt++;
            if (bus.done && done_lat < 0) done_lat = lat;
        end
        if (bus.busy) check("busy_timeout", lat, 0);
        if (chk_lat) begin
            check("done_latency", done_lat, (b == 4'd0) ? 1 : 8);
            check("busy_cycles", busy_cnt, (b == 4'd0) ? 2 : 9);
        end
        $display("op %0d / %0d -> q=%0d r=%0d dz=%0d", a, b, bus.quotient, bus.remainder, bus.div_by_zero);
    endtask

    initial begin
        vecs[0] = '{dvd: 8'd200, dvs: 4'd7,  q: 8'd28,  r: 4'd4, dz: 1'b0};
        vecs[1] = '{dvd: 8'd255, dvs: 4'd9,  q: 8'd28,  r: 4'd3, dz: 1'b0};
        vecs[2] = '{dvd: 8'd255, dvs: 4'd15, q: 8'd17,  r: 4'd0, dz: 1'b0};
        vecs[3] = '{dvd: 8'd255, dvs: 4'd1,  q: 8'd255, r: 4'd0, dz: 1'b0};
        vecs[4] = '{dvd: 8'd3,   dvs: 4'd9,  q: 8'd0,   r: 4'd3, dz: 1'b0};
        vecs[5] = '{dvd: 8'd0,   dvs: 4'd5,  q: 8'd0,   r: 4'd0, dz: 1'b0};
        vecs[6] = '{dvd: 8'd15,  dvs: 4'd0,  q: 8'hFF,  r: 4'd0, dz: 1'b1};

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_quotient", int'(bus.quotient), 0);
        check("rst_remainder", int'(bus.remainder), 0);
        check("rst_div_by_zero", int'(bus.div_by_zero), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dz, 1'b1);
            repeat (3) @(posedge clk);
            #1;
            check("hold_quotient", int'(bus.quotient), int'(vecs[i].q));
            check("hold_remainder", int'(bus.remainder), int'(vecs[i].r));
            check("hold_div_by_zero", int'(bus.div_by_zero), int'(vecs[i].dz));
        end

        // start re-asserted during CALC must be ignored
        begin
            int lat;
            exp_t e;
            e.q = 8'd33; e.r = 4'd1; e.dz = 1'b0;
            sb_q.push_back(e);
            bus.dividend = 8'd100;
            bus.divisor  = 4'd3;
            bus.start    = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            bus.dividend = 8'd50;
            bus.divisor  = 4'd5;
            bus.start    = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
            lat = 0;
            while (bus.busy && lat < 30) begin
                @(posedge clk);
                #1;
                lat++;
            end
            if (bus.busy) check("busy_timeout", lat, 0);
            check("ignored_start_quotient", int'(bus.quotient), 33);
            $display("op 100 / 3 with ignored 50 / 5 -> q=%0d r=%0d", bus.quotient, bus.remainder);
        end

        // reset in the middle of CALC aborts without a done pulse
        bus.dividend = 8'd200;
        bus.divisor  = 4'd7;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_quotient", int'(bus.quotient), 0);
        check("abort_remainder", int'(bus.remainder), 0);
        check("abort_div_by_zero", int'(bus.div_by_zero), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_pending", sb_q.size(), 0);
        check("abort_idle_busy", int'(bus.busy), 0);
        $display("reset abort of 200 / 7 -> busy=%0d q=%0d", bus.busy, bus.quotient);
        run_op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 1'b1);

        // back-to-back sweep of every operand pair
        for (int b = 0; b < 16; b++) begin
            for (int a = 0; a < 256; a++) begin
                if (b == 0)
                    run_op(8'(a), 4'(b), 8'hFF, 4'd0, 1'b1, 1'b0);
                else
                    run_op(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 1'b0);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
